// File: rtl/pipe_pkg.sv
// Purpose: shared types and constants for the MIPS pipeline-stage registers.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pipe_pkg;

    // Occupancy of a stage register. The encoding equals the live-entry count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_t;

    // All-zero word is sll $0,$0,0, so it doubles as the bubble value.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Per-boundary payload widths. The packing itself lives in each stage.
    // IF/ID : instr(32) + pc_plus4(32)
    localparam int unsigned IF_ID_W  = 64;
    // ID/EX : pc_plus4(32) + rs_dat(32) + rt_dat(32) + imm(32) + rs/rt/rd(15) + ctrl(9)
    localparam int unsigned ID_EX_W  = 152;
    // EX/MEM: alu_res(32) + store_dat(32) + rd(5) + ctrl(5)
    localparam int unsigned EX_MEM_W = 74;
    // MEM/WB: load_dat(32) + alu_res(32) + rd(5) + ctrl(2)
    localparam int unsigned MEM_WB_W = 71;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Purpose: valid/ready bundle around one elastic pipeline-stage register.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready carry it; flush kills held entries.
// Ports: in_valid/in_ready/in_data upstream side, out_valid/out_ready/out_data
//        downstream side, flush kill strobe, count occupancy (0..2).
//        master = whoever drives the stage, slave = the stage itself.
interface pipe_stage_reg_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       count;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Purpose: elastic MIPS pipeline-stage register with optional 2-entry skid and flush-to-bubble.
// Latency: 1 cycle from push to out_data; 1 word/cycle with out_ready held high.
// Backpressure: SKID=1 registered in_ready (falls only when both entries live); SKID=0 in_ready = empty | out_ready.
// Ports: clk, rst_n (async, active low); bus (slave modport) carries the
//        in_* handshake, out_* handshake, flush and the count of live entries.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH       = 32,
    parameter bit               SKID        = 1'b1,
    parameter logic [WIDTH-1:0] FLUSH_VALUE = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    pipe_stage_reg_if.slave bus
);

    stage_state_t     state_q;
    stage_state_t     state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic             main_en;
    logic [WIDTH-1:0] skid_q;
    logic             skid_en;
    logic             in_ready;
    logic             out_valid;
    logic             push;
    logic             pop;

    always_comb begin
        in_ready = 1'b0;
        if (SKID) begin
            // Depends on state only, so no out_ready -> in_ready path exists.
            in_ready = (state_q != TWO);
        end else begin
            in_ready = (state_q == EMPTY) | bus.out_ready;
        end
    end

    assign out_valid = (state_q != EMPTY);
    assign push      = bus.in_valid & in_ready;
    assign pop       = out_valid & bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = main_q;
    assign bus.count     = state_q;

    always_comb begin
        state_d = state_q;
        main_d  = bus.in_data;
        main_en = 1'b0;
        skid_en = 1'b0;
        if (bus.flush) begin
            // A same-cycle pop still completes (downstream took the old head);
            // a same-cycle push is dropped.
            state_d = EMPTY;
            main_d  = FLUSH_VALUE;
            main_en = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        main_en = 1'b1;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_en = 1'b1;
                    end else if (push) begin
                        // Only reachable with SKID=1: with SKID=0 a push in
                        // ONE implies out_ready, hence a pop.
                        if (SKID) begin
                            skid_en = 1'b1;
                            state_d = TWO;
                        end
                    end else if (pop) begin
                        // main keeps its stale value
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        main_d  = skid_q;
                        main_en = 1'b1;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= FLUSH_VALUE;
            skid_q <= FLUSH_VALUE;
        end else begin
            if (main_en) begin
                main_q <= main_d;
            end
            if (skid_en) begin
                skid_q <= bus.in_data;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Purpose: bench for pipe_stage_reg with SKID=1 (u_dut1) and SKID=0 (u_dut0).
// Latency: n/a.
// Backpressure: n/a.
module tb_pipe_stage_reg;

    logic clk;
    logic rst_n;

    pipe_stage_reg_if #(.WIDTH(32)) b1 ();
    pipe_stage_reg_if #(.WIDTH(32)) b0 ();

    pipe_stage_reg #(.WIDTH(32), .SKID(1'b1), .FLUSH_VALUE(32'h0)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    pipe_stage_reg #(.WIDTH(32), .SKID(1'b0), .FLUSH_VALUE(32'h0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          iv;
        logic [31:0] id;
        bit          fl;
        bit          ordy;
        bit          e_ir;
        bit          e_ov;
        logic [1:0]  e_cnt;
        logic [31:0] e_od;
    } vec_t;

    vec_t        tbl1[$];
    vec_t        tbl0[$];
    logic [31:0] sb_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;

    function automatic vec_t mk(bit iv, logic [31:0] id, bit fl, bit ordy,
                                bit ir, bit ov, logic [1:0] cnt, logic [31:0] od);
        vec_t v;
        v.iv = iv; v.id = id; v.fl = fl; v.ordy = ordy;
        v.e_ir = ir; v.e_ov = ov; v.e_cnt = cnt; v.e_od = od;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input bit iv, input logic [31:0] id,
                         input bit fl, input bit ordy);
        if (sel) begin
            b1.in_valid = iv; b1.in_data = id; b1.flush = fl; b1.out_ready = ordy;
        end else begin
            b0.in_valid = iv; b0.in_data = id; b0.flush = fl; b0.out_ready = ordy;
        end
    endtask

    // Entered at posedge+1; returns at the next posedge+1.
    task automatic apply_row(input bit sel, input vec_t v, input int idx);
        logic        ir, ov;
        logic [1:0]  cnt;
        logic [31:0] od;
        logic [31:0] exp_w;
        drive(sel, v.iv, v.id, v.fl, v.ordy);
        #1;
        if (sel) begin
            ir = b1.in_ready; ov = b1.out_valid; cnt = b1.count; od = b1.out_data;
        end else begin
            ir = b0.in_ready; ov = b0.out_valid; cnt = b0.count; od = b0.out_data;
        end
        chk($sformatf("skid%0d row%0d in_ready", sel, idx), 32'(ir), 32'(v.e_ir));
        chk($sformatf("skid%0d row%0d out_valid", sel, idx), 32'(ov), 32'(v.e_ov));
        chk($sformatf("skid%0d row%0d count", sel, idx), 32'(cnt), 32'(v.e_cnt));
        chk($sformatf("skid%0d row%0d out_data", sel, idx), od, v.e_od);
        // scoreboard: pop completes before flush discards the rest
        if (v.e_ov && v.ordy) begin
            if (sb_q.size() == 0) begin
                chk($sformatf("skid%0d row%0d pop on empty scoreboard", sel, idx), 32'(1), 32'(0));
            end else begin
                exp_w = sb_q.pop_front();
                chk($sformatf("skid%0d row%0d popped word", sel, idx), od, exp_w);
            end
        end
        if (v.fl) begin
            sb_q.delete();
        end else if (v.iv && v.e_ir) begin
            sb_q.push_back(v.id);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // SKID=1: pass-through, skid absorption, flush in TWO / ONE / with pop
        tbl1.push_back(mk(1, 32'h1111_1111, 0, 1,  1, 0, 2'd0, 32'h0));
        tbl1.push_back(mk(1, 32'h2222_2222, 0, 1,  1, 1, 2'd1, 32'h1111_1111));
        tbl1.push_back(mk(0, 32'h0,         0, 1,  1, 1, 2'd1, 32'h2222_2222));
        tbl1.push_back(mk(0, 32'h0,         0, 0,  1, 0, 2'd0, 32'h2222_2222));
        tbl1.push_back(mk(1, 32'hA,         0, 0,  1, 0, 2'd0, 32'h2222_2222));
        tbl1.push_back(mk(1, 32'hB,         0, 0,  1, 1, 2'd1, 32'hA));
        tbl1.push_back(mk(1, 32'hC,         0, 0,  0, 1, 2'd2, 32'hA));
        tbl1.push_back(mk(1, 32'hC,         0, 1,  0, 1, 2'd2, 32'hA));
        tbl1.push_back(mk(1, 32'hC,         0, 1,  1, 1, 2'd1, 32'hB));
        tbl1.push_back(mk(0, 32'h0,         0, 1,  1, 1, 2'd1, 32'hC));
        tbl1.push_back(mk(0, 32'h0,         0, 0,  1, 0, 2'd0, 32'hC));
        tbl1.push_back(mk(1, 32'h11,        0, 0,  1, 0, 2'd0, 32'hC));
        tbl1.push_back(mk(1, 32'h22,        0, 0,  1, 1, 2'd1, 32'h11));
        tbl1.push_back(mk(1, 32'hDEAD_BEEF, 1, 0,  0, 1, 2'd2, 32'h11));
        tbl1.push_back(mk(0, 32'h0,         0, 1,  1, 0, 2'd0, 32'h0));
        tbl1.push_back(mk(1, 32'h33,        0, 0,  1, 0, 2'd0, 32'h0));
        tbl1.push_back(mk(1, 32'hDEAD_BEEF, 1, 0,  1, 1, 2'd1, 32'h33));
        tbl1.push_back(mk(0, 32'h0,         0, 1,  1, 0, 2'd0, 32'h0));
        tbl1.push_back(mk(1, 32'h5,         0, 0,  1, 0, 2'd0, 32'h0));
        tbl1.push_back(mk(0, 32'h0,         1, 1,  1, 1, 2'd1, 32'h5));
        tbl1.push_back(mk(0, 32'h0,         0, 1,  1, 0, 2'd0, 32'h0));
        // SKID=0: combinational in_ready, replace-in-place, stall hold, flush
        tbl0.push_back(mk(1, 32'hAAAA_0001, 0, 1,  1, 0, 2'd0, 32'h0));
        tbl0.push_back(mk(1, 32'hAAAA_0002, 0, 0,  0, 1, 2'd1, 32'hAAAA_0001));
        tbl0.push_back(mk(1, 32'hAAAA_0002, 0, 1,  1, 1, 2'd1, 32'hAAAA_0001));
        tbl0.push_back(mk(1, 32'hAAAA_0003, 0, 1,  1, 1, 2'd1, 32'hAAAA_0002));
        tbl0.push_back(mk(0, 32'h0,         0, 0,  0, 1, 2'd1, 32'hAAAA_0003));
        tbl0.push_back(mk(0, 32'h0,         0, 0,  0, 1, 2'd1, 32'hAAAA_0003));
        tbl0.push_back(mk(0, 32'h0,         0, 1,  1, 1, 2'd1, 32'hAAAA_0003));
        tbl0.push_back(mk(0, 32'h0,         0, 0,  1, 0, 2'd0, 32'hAAAA_0003));
        tbl0.push_back(mk(1, 32'hAAAA_0004, 1, 0,  1, 0, 2'd0, 32'hAAAA_0003));
        tbl0.push_back(mk(0, 32'h0,         0, 0,  1, 0, 2'd0, 32'h0));

        rst_n = 1'b0;
        drive(1'b1, 0, 32'h0, 0, 0);
        drive(1'b0, 0, 32'h0, 0, 0);
        repeat (2) @(posedge clk);
        #2;
        chk("reset skid1 out_valid", 32'(b1.out_valid), 32'(0));
        chk("reset skid1 out_data", b1.out_data, 32'h0);
        chk("reset skid1 count", 32'(b1.count), 32'(0));
        chk("reset skid1 in_ready", 32'(b1.in_ready), 32'(1));
        chk("reset skid0 out_valid", 32'(b0.out_valid), 32'(0));
        chk("reset skid0 in_ready", 32'(b0.in_ready), 32'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl1[i]) apply_row(1'b1, tbl1[i], i);
        chk("skid1 scoreboard drained", 32'(sb_q.size()), 32'(0));
        drive(1'b1, 0, 32'h0, 0, 0);

        foreach (tbl0[i]) apply_row(1'b0, tbl0[i], i);
        chk("skid0 scoreboard drained", 32'(sb_q.size()), 32'(0));
        drive(1'b0, 0, 32'h0, 0, 0);

        // Fill SKID=1 stage to TWO, then reset between clock edges.
        apply_row(1'b1, mk(1, 32'h61, 0, 0,  1, 0, 2'd0, 32'h0), 100);
        apply_row(1'b1, mk(1, 32'h62, 0, 0,  1, 1, 2'd1, 32'h61), 101);
        drive(1'b1, 0, 32'h0, 0, 0);
        #1;
        chk("pre-reset count", 32'(b1.count), 32'(2));
        #1;
        rst_n = 1'b0;
        #1;
        chk("async reset out_valid", 32'(b1.out_valid), 32'(0));
        chk("async reset count", 32'(b1.count), 32'(0));
        chk("async reset in_ready", 32'(b1.in_ready), 32'(1));
        chk("async reset out_data", b1.out_data, 32'h0);
        sb_q.delete();
        #2;
        rst_n = 1'b1;
        drive(1'b1, 1, 32'h77, 0, 1);
        @(posedge clk);
        #1;
        chk("first push after reset out_valid", 32'(b1.out_valid), 32'(1));
        chk("first push after reset out_data", b1.out_data, 32'h77);
        chk("first push after reset count", 32'(b1.count), 32'(1));
        drive(1'b1, 0, 32'h0, 0, 1);
        @(posedge clk);
        #1;
        chk("drain after reset out_valid", 32'(b1.out_valid), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline-stage register for the MIPS pipeline, the common building block for the IF/ID, ID/EX, EX/MEM and MEM/WB boundaries. It replaces the fixed-width, always-loading stage registers with a valid/ready handshake, an optional two-entry skid buffer, and a synchronous flush that inserts a bubble. Each payload (instruction, PC+4, control bundles, operands) is packed by the instantiating stage into one WIDTH-bit word.

## Interface

Parameters:
- WIDTH, 32: payload width in bits; legal range 1 to 1024.
- SKID, 1: 1 selects a two-entry skid buffer with registered in_ready; 0 selects a single entry with combinational in_ready.
- FLUSH_VALUE, 0: WIDTH-bit word loaded into the output register on reset and on flush. 0 is the NOP instruction.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  stage can accept a word this cycle.
- in_data  input  WIDTH  upstream payload.
- flush  input  1  synchronous kill of all held entries (branch or IF_Flush).
- out_valid  output  1  out_data holds a live entry.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  WIDTH  head entry. Driven directly from the main register.
- count  output  2  number of live entries: 0, 1 or 2.

## Operation

- push = in_valid & in_ready. pop = out_valid & out_ready. Both are evaluated at the rising edge of clk.
- States are EMPTY (count 0), ONE (main register live) and TWO (main and skid registers live). TWO exists only when SKID=1.
- EMPTY: on push, load main with in_data and go to ONE.
- ONE, push with no pop: with SKID=1, load skid with in_data and go to TWO.
- ONE, push with pop: load main with in_data and stay in ONE.
- ONE, pop with no push: go to EMPTY. Main keeps its stale value.
- TWO: on pop, load main from skid and go to ONE. No push can occur in TWO because in_ready is 0.
- in_ready:
  - SKID=1: in_ready = (state != TWO). It is a pure function of the state register, with no combinational path from out_ready.
  - SKID=0: in_ready = (state == EMPTY) | out_ready.
- out_valid = (state != EMPTY). count follows the state: 0, 1 or 2.
- flush has priority over everything else:
  - Next state is EMPTY and main is loaded with FLUSH_VALUE.
  - A push in the same cycle is discarded. Upstream treats it as killed.
  - A pop in the same cycle completes normally: downstream consumed the pre-flush head.
- Stall rule: while out_valid=1 and out_ready=0, out_data must hold its value.
- Upstream must not drop in_valid or change in_data until push occurs. The block does not check this; verification asserts it.

## Timing

- Reset (rst_n low, asynchronous): state EMPTY, out_valid 0, count 0, in_ready 1, out_data FLUSH_VALUE. The skid register resets to FLUSH_VALUE.
- Latency is 1 cycle: in_data pushed at edge N appears on out_data with out_valid=1 after edge N.
- Throughput is 1 word per cycle when out_ready is held at 1, for both SKID settings.
- SKID=1 stall absorption:
  - The first cycle of downstream stall absorbs one extra word into skid, and in_ready falls after that edge.
  - After out_ready returns, the first pop moves skid into main. in_ready rises after the same edge.
- Reset asserted mid-transfer: all entries are lost immediately, without waiting for the clock. The first push is accepted at the first clk edge after rst_n deassertion.
- flush and reset leave the skid register contents don't-care. Only count and the state are architecturally visible.

## Structure

- Shared package pipe_pkg holds:
  - the stage_state_t enum (EMPTY, ONE, TWO);
  - NOP_INSTR = 32'h0000_0000;
  - the per-boundary payload width constants IF_ID_W, ID_EX_W, EX_MEM_W, MEM_WB_W.
- Single module with no sub-module. The FSM and both data registers fit in one block. The per-boundary payload packing belongs in the instantiating stage.

## Test plan

- Reset and pass-through (WIDTH=32, SKID=1, FLUSH_VALUE=0):
  - Stimulus: hold rst_n low, release it, then push 32'h1111_1111 and 32'h2222_2222 back to back with out_ready=1.
  - Required response: out_data equals FLUSH_VALUE and out_valid=0 while in reset. Afterwards, out_data shows each word one cycle after its push, with out_valid=1 and count=1.
- Skid absorption (SKID=1):
  - Stimulus: drop out_ready while pushing A=32'hA, B=32'hB, C=32'hC.
  - Required response: A is held on out_data, B goes into skid, count=2, in_ready=0 and C is held off. After out_ready=1, the outputs are A, B, C on consecutive cycles with no loss or duplication.
- Flush with push:
  - Stimulus: in state TWO, assert flush together with a push of 32'hDEAD_BEEF.
  - Required response: next cycle, out_valid=0, count=0 and out_data=0. 32'hDEAD_BEEF never appears on the output.
- Flush with pop:
  - Stimulus: in ONE holding 32'h5, assert flush with out_ready=1.
  - Required response: 32'h5 is consumed once, then the stage is EMPTY.
- SKID=0 back-pressure:
  - Stimulus: set out_ready=0 while in ONE.
  - Required response: in_ready=0 in the same cycle. When out_ready=1 with in_valid=1, the entry is replaced in a single cycle and count stays 1.
- Asynchronous reset mid-stream:
  - Stimulus: pulse rst_n low between clock edges while in state TWO.
  - Required response: out_valid falls immediately with no clk edge needed, count=0, and in_ready=1.
